// File: rtl/pair_shuffle_gen.sv
// Pair-shuffle board generator: builds 2*num_pairs cards (each symbol twice),
// shuffles them with a rejection-sampled Fisher-Yates driven by a 16-bit LFSR,
// and publishes the finished board with a one-cycle done pulse.
module pair_shuffle_gen #(
    parameter int unsigned MAX_CARDS = 16,
    parameter int unsigned IDX_W     = 4,
    parameter int unsigned SYM_W     = 3,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [IDX_W-1:0]             num_pairs,
    input  logic                         seed_load,
    input  logic [15:0]                  seed_in,
    output logic                         busy,
    output logic                         done,
    output logic [MAX_CARDS*SYM_W-1:0]   map,
    output logic [MAX_CARDS-1:0]         cell_valid
);

    localparam int unsigned N_W  = IDX_W + 1;
    localparam int unsigned HALF = MAX_CARDS / 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_INIT,
        S_SHUFFLE,
        S_DONE
    } state_t;

    state_t                     state_q;
    logic                       busy_q;
    logic                       done_q;
    logic [MAX_CARDS*SYM_W-1:0] map_q;
    logic [MAX_CARDS-1:0]       cell_valid_q;
    logic [15:0]                lfsr_q;
    logic [15:0]                lfsr_d;
    logic [N_W-1:0]             n_q;
    logic [N_W-1:0]             n_d;
    logic [IDX_W-1:0]           i_q;
    logic [IDX_W-1:0]           mask_d;
    logic [IDX_W-1:0]           r_d;
    logic                       accept_d;
    logic [SYM_W-1:0]           deck_q [MAX_CARDS];
    logic [SYM_W-1:0]           deck_d [MAX_CARDS];

    assign busy       = busy_q;
    assign done       = done_q;
    assign map        = map_q;
    assign cell_valid = cell_valid_q;

    // Next LFSR value: a seed load overrides the shift; a zero seed falls back to SEED.
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        if (seed_load) begin
            lfsr_d = (seed_in == 16'h0000) ? SEED : seed_in;
        end
    end

    // Card count at start: out-of-range pair counts select the full board.
    always_comb begin
        n_d = N_W'(MAX_CARDS);
        if ((num_pairs != '0) && (N_W'(num_pairs) <= N_W'(HALF))) begin
            n_d = {num_pairs, 1'b0};
        end
    end

    // Draw: smear i into an all-ones mask, take masked LFSR bits, accept if r <= i.
    always_comb begin
        mask_d = i_q;
        for (int s = 1; s < int'(IDX_W); s++) begin
            mask_d = mask_d | (i_q >> s);
        end
        r_d      = lfsr_q[IDX_W-1:0] & mask_d;
        accept_d = (r_d <= i_q);
    end

    // Deck after swapping positions i and r (only committed on an accepted draw).
    always_comb begin
        for (int k = 0; k < int'(MAX_CARDS); k++) begin
            deck_d[k] = deck_q[k];
        end
        deck_d[i_q] = deck_q[r_d];
        deck_d[r_d] = deck_q[i_q];
    end

    // Control FSM, LFSR, deck storage and the registered board outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            map_q        <= '0;
            cell_valid_q <= '0;
            lfsr_q       <= SEED;
            n_q          <= '0;
            i_q          <= '0;
            for (int k = 0; k < int'(MAX_CARDS); k++) begin
                deck_q[k] <= '0;
            end
        end else begin
            lfsr_q <= lfsr_d;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        n_q     <= n_d;
                        busy_q  <= 1'b1;
                        state_q <= S_INIT;
                    end
                end
                S_INIT: begin
                    for (int k = 0; k < int'(MAX_CARDS); k++) begin
                        deck_q[k] <= (k < int'(n_q)) ? SYM_W'(k >> 1) : '0;
                    end
                    i_q     <= IDX_W'(n_q - N_W'(1));
                    state_q <= S_SHUFFLE;
                end
                S_SHUFFLE: begin
                    if (accept_d) begin
                        for (int k = 0; k < int'(MAX_CARDS); k++) begin
                            deck_q[k] <= deck_d[k];
                        end
                        i_q <= i_q - IDX_W'(1);
                        if (i_q == IDX_W'(1)) begin
                            // Last swap: publish the finished board together with done.
                            for (int k = 0; k < int'(MAX_CARDS); k++) begin
                                map_q[k*SYM_W +: SYM_W] <= deck_d[k];
                                cell_valid_q[k]         <= (k < int'(n_q));
                            end
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pair_shuffle_gen.sv
// Bench for pair_shuffle_gen: directed and randomized boards checked against
// an array-based Fisher-Yates reference fed by the same LFSR sequence.
module tb_pair_shuffle_gen;

    localparam int unsigned MAXC   = 16;
    localparam int unsigned IDXW   = 4;
    localparam int unsigned SYMW   = 3;
    localparam logic [15:0] SEED_V = 16'hACE1;

    logic                  clk;
    logic                  reset;
    logic                  start;
    logic [IDXW-1:0]       num_pairs;
    logic                  seed_load;
    logic [15:0]           seed_in;
    logic                  busy;
    logic                  done;
    logic [MAXC*SYMW-1:0]  map;
    logic [MAXC-1:0]       cell_valid;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [15:0] mdl_lfsr;

    pair_shuffle_gen #(
        .MAX_CARDS(MAXC),
        .IDX_W    (IDXW),
        .SYM_W    (SYMW),
        .SEED     (SEED_V)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_pairs (num_pairs),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .busy      (busy),
        .done      (done),
        .map       (map),
        .cell_valid(cell_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Reference board: Fisher-Yates over an int array, rejecting draws above i.
    function automatic void predict(input logic [15:0] l0, input int n,
                                    output int draws, output logic [MAXC*SYMW-1:0] em);
        int          deck [MAXC];
        logic [15:0] l;
        int          i, m, r, t;
        for (int k = 0; k < int'(MAXC); k++) deck[k] = (k < n) ? k / 2 : 0;
        l     = step(step(l0));
        i     = n - 1;
        draws = 0;
        while (i > 0 && draws < 100000) begin
            m = 1;
            while (m < i) m = 2 * m + 1;
            r = int'(l[IDXW-1:0]) & m;
            draws++;
            l = step(l);
            if (r <= i) begin
                t = deck[i]; deck[i] = deck[r]; deck[r] = t;
                i--;
            end
        end
        em = '0;
        for (int k = 0; k < int'(MAXC); k++) em[k*SYMW +: SYMW] = SYMW'(deck[k]);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: advance the LFSR model using the inputs applied in this cycle.
    task automatic tick();
        logic [15:0] nx;
        if (reset)          nx = SEED_V;
        else if (seed_load) nx = (seed_in == 16'h0000) ? SEED_V : seed_in;
        else                nx = step(mdl_lfsr);
        @(posedge clk);
        #1;
        mdl_lfsr = nx;
        cyc++;
    endtask

    task automatic load_seed(input logic [15:0] s);
        seed_load = 1'b1;
        seed_in   = s;
        tick();
        seed_load = 1'b0;
    endtask

    // Start a board from idle, wait for done, check the result and handshake.
    task automatic run_board(input int np, input bit pulse, output logic [MAXC*SYMW-1:0] got_map);
        int                   n, draws, t0, cnt [MAXC];
        bit                   got, stable, ok;
        logic [MAXC*SYMW-1:0] prev, em;
        logic [31:0]          ev;
        n = (np >= 1 && np <= int'(MAXC / 2)) ? 2 * np : int'(MAXC);
        predict(mdl_lfsr, n, draws, em);
        ev        = (32'd1 << n) - 32'd1;
        prev      = map;
        start     = 1'b1;
        num_pairs = IDXW'(np);
        t0        = cyc;
        tick();
        start = pulse;
        check("busy_rise", busy, 1);
        got    = 0;
        stable = 1;
        for (int w = 0; w < 600; w++) begin
            if (done === 1'b1) begin
                got = 1;
                break;
            end
            if (map !== prev) stable = 0;
            if (pulse) begin
                start     = 1'b1;
                num_pairs = IDXW'($urandom_range(0, 15));
            end
            tick();
        end
        check("done_seen", got, 1);
        check("map_stable_before_done", stable, 1);
        check("latency", cyc - t0, draws + 2);
        check("map", map, em);
        check("cell_valid", cell_valid, ev[MAXC-1:0]);
        check("busy_at_done", busy, 1);
        for (int s = 0; s < int'(MAXC); s++) cnt[s] = 0;
        ok = 1;
        for (int k = 0; k < int'(MAXC); k++) begin
            if (k < n) cnt[int'(map[k*SYMW +: SYMW])]++;
            else if (map[k*SYMW +: SYMW] !== '0) ok = 0;
        end
        for (int s = 0; s < int'(MAXC); s++) begin
            if (s < n / 2 && cnt[s] != 2) ok = 0;
            if (s >= n / 2 && cnt[s] != 0) ok = 0;
        end
        check("pair_counts", ok, 1);
        got_map = map;
        start   = 1'b0;
        tick();
        check("done_one_cycle", done, 0);
        check("busy_fall", busy, 0);
        check("map_hold", map, got_map);
    endtask

    initial begin
        logic [MAXC*SYMW-1:0] m, m1, m2, m3;
        bit                   seen;
        reset     = 1'b1;
        start     = 1'b0;
        num_pairs = '0;
        seed_load = 1'b0;
        seed_in   = '0;
        mdl_lfsr  = '0;

        // Reset state
        tick();
        tick();
        reset = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_map", map, 0);
        check("rst_cell_valid", cell_valid, 0);
        run_board(8, 0, m);

        // Seeded full board, then a partial board
        load_seed(16'h1234);
        run_board(8, 0, m);
        run_board(3, 0, m);
        check("p3_valid", cell_valid, 16'h003F);

        // Start hammered while busy; out-of-range pair counts clamp to 16 cards
        run_board(5, 1, m);
        run_board(0, 1, m);
        check("np0_valid", cell_valid, 16'hFFFF);
        run_board(9, 1, m);
        check("np9_valid", cell_valid, 16'hFFFF);

        // Determinism and seed sensitivity
        load_seed(16'hBEEF);
        run_board(8, 0, m1);
        load_seed(16'hBEEF);
        run_board(8, 0, m2);
        check("repeat_same_map", m2, m1);
        load_seed(16'h1235);
        run_board(8, 0, m3);
        check("seed_changes_map", (m3 !== m1), 1);

        // Zero seed falls back to the default seed
        load_seed(16'h0000);
        run_board(6, 0, m);

        // Reset in the middle of a shuffle
        start     = 1'b1;
        num_pairs = 4'd8;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_map", map, 0);
        check("midrst_valid", cell_valid, 0);
        seen = 0;
        for (int w = 0; w < 40; w++) begin
            if (done === 1'b1 || busy === 1'b1) seen = 1;
            tick();
        end
        check("midrst_no_done", seen, 0);
        run_board(8, 0, m);

        // Randomized boards with random seeds and idle gaps
        for (int it = 0; it < 10; it++) begin
            if ($urandom_range(0, 1) == 1) load_seed(16'($urandom));
            repeat ($urandom_range(0, 3)) tick();
            run_board(int'($urandom_range(0, 15)), bit'($urandom_range(0, 1)), m);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
